// File: rtl/emu_pkg.sv
// Shared types and constants for the emulator core and its memory responder.
package emu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam int WORD_W = 32;

  // Register indices used by the emulator core.
  localparam int PC = 15;
  localparam int SP = 13;

endpackage

// File: rtl/emu_mem_wait_ctr.sv
// Loadable down-counter that paces the wait states of a memory transaction.
module emu_mem_wait_ctr #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         done
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/emu_mem_responder.sv
// Word-organised memory responder with configurable wait states and one outstanding request.
// Optional store protection of the code region: define EMU_MEM_CODE_PROTECT_EN.
module emu_mem_responder
  import emu_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 1,
  parameter int CODE_WORDS  = 256
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH);
`ifdef EMU_MEM_CODE_PROTECT_EN
  localparam bit PROTECT_EN = 1'b1;
`else
  localparam bit PROTECT_EN = 1'b0;
`endif
  localparam logic [3:0] LOAD_VAL = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t              state_q, state_d;
  logic                write_q, write_d;
  logic [31:0]         addr_q, addr_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic [3:0]          be_q, be_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_err_q, rsp_err_d;
  logic [WORD_W-1:0]   rsp_rdata_q;

  logic                ctr_load, ctr_dec, ctr_done, enter_resp;
  logic                acc_write, acc_err, load_ok, mem_we;
  logic [31:0]         acc_addr;
  logic [WORD_W-1:0]   acc_wdata;
  logic [3:0]          acc_be;
  logic [AW-1:0]       acc_idx;

  logic [WORD_W-1:0]   mem [DEPTH];

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  // With zero wait states the access happens on the accept edge, so it must see the live request.
  always_comb begin
    acc_write = write_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    acc_be    = be_q;
    if (state_q == IDLE) begin
      acc_write = req_write;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_be    = req_be;
    end
  end

  assign acc_idx = acc_addr[AW+1:2];
  assign acc_err = (acc_addr[1:0] != 2'b00)
                || (acc_addr[31:AW+2] != '0)
                || (PROTECT_EN && acc_write && (32'(acc_idx) < CODE_WORDS));
  assign load_ok = !acc_write && !acc_err;
  assign mem_we  = enter_resp && acc_write && !acc_err && reset_n;

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    ctr_load    = 1'b0;
    ctr_dec     = 1'b0;
    enter_resp  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          if (WAIT_STATES == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            ctr_load = 1'b1;
            state_d  = WAIT;
          end
        end
      end
      WAIT: begin
        if (ctr_done) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          ctr_dec = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (enter_resp) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = acc_err;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      if (enter_resp) begin
        rsp_rdata_q <= load_ok ? mem[acc_idx] : '0;
      end
    end
  end

  // Memory contents survive reset; only byte lanes with an enable are written.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_be[i]) begin
          mem[acc_idx][i*8 +: 8] <= acc_wdata[i*8 +: 8];
        end
      end
    end
  end

  emu_mem_wait_ctr #(
    .W(4)
  ) u_wait_ctr (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (ctr_load),
    .load_val (LOAD_VAL),
    .dec      (ctr_dec),
    .done     (ctr_done)
  );

endmodule

// File: tb/tb_emu_mem_responder.sv
// Directed bench: instance 0 uses one wait state, instance 1 uses four.
module tb_emu_mem_responder;

  logic        clk;
  logic        reset_n;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_write [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_be    [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  int tests = 0;
  int fails = 0;

  emu_mem_responder #(.DEPTH(1024), .WAIT_STATES(1), .CODE_WORDS(256)) u_dut_ws1 (
    .clock(clk), .reset_n(reset_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0])
  );

  emu_mem_responder #(.DEPTH(1024), .WAIT_STATES(4), .CODE_WORDS(256)) u_dut_ws4 (
    .clock(clk), .reset_n(reset_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One full transaction with rsp_ready high; checks accept-to-valid latency in clock edges.
  task automatic do_req(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, input string tag,
                        output logic [31:0] rd, output logic er);
    int n;
    @(negedge clk);
    req_write[d] = w;
    req_addr[d]  = a;
    req_wdata[d] = wd;
    req_be[d]    = be;
    req_valid[d] = 1'b1;
    n = 0;
    while (req_ready[d] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    req_valid[d] = 1'b0;
    n = 1;
    while (rsp_valid[d] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".latency"}, 32'(n), (d == 0) ? 32'd2 : 32'd5);
    rd = rsp_rdata[d];
    er = rsp_err[d];
    @(negedge clk);
    check({tag, ".rsp_cleared"}, {31'd0, rsp_valid[d]}, 32'd0);
    $display("[TB] dut%0d %s write=%0b addr=0x%08h wdata=0x%08h be=%b -> rdata=0x%08h err=%0b",
             d, tag, w, a, wd, be, rd, er);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] held;
    int          n;

    reset_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0;
      req_write[d] = 1'b0;
      req_addr[d]  = '0;
      req_wdata[d] = '0;
      req_be[d]    = '0;
      rsp_ready[d] = 1'b1;
    end
    repeat (2) @(negedge clk);
    check("reset.req_ready", {31'd0, req_ready[0]}, 32'd1);
    check("reset.rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);
    check("reset.rsp_rdata", rsp_rdata[0], 32'd0);
    check("reset.rsp_err",   {31'd0, rsp_err[0]}, 32'd0);
    reset_n = 1'b1;

    // Full store, then load back.
    do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, "store_full", rd, er);
    check("store_full.rdata", rd, 32'd0);
    check("store_full.err", {31'd0, er}, 32'd0);
    do_req(0, 1'b0, 32'h10, 32'h0, 4'b0000, "load_full", rd, er);
    check("load_full.rdata", rd, 32'hDEADBEEF);
    check("load_full.err", {31'd0, er}, 32'd0);

    // Lane 0 only.
    do_req(0, 1'b1, 32'h10, 32'h000000AA, 4'b0001, "store_lane0", rd, er);
    do_req(0, 1'b0, 32'h10, 32'h0, 4'b1111, "load_lane0", rd, er);
    check("load_lane0.rdata", rd, 32'hDEADBEAA);

    // No byte enables: legal no-op.
    do_req(0, 1'b1, 32'h10, 32'h12345678, 4'b0000, "store_be0", rd, er);
    check("store_be0.err", {31'd0, er}, 32'd0);
    do_req(0, 1'b0, 32'h10, 32'h0, 4'b0000, "load_be0", rd, er);
    check("load_be0.rdata", rd, 32'hDEADBEAA);

    // Seed the words an out-of-range store could alias onto.
    do_req(0, 1'b1, 32'h0, 32'h5A5A5A5A, 4'b1111, "store_w0", rd, er);
    do_req(0, 1'b1, 32'hFFC, 32'hCAFEF00D, 4'b1111, "store_last", rd, er);

    do_req(0, 1'b0, 32'h12, 32'h0, 4'b0000, "load_misaligned", rd, er);
    check("load_misaligned.err", {31'd0, er}, 32'd1);
    check("load_misaligned.rdata", rd, 32'd0);

    do_req(0, 1'b1, 32'h1000, 32'hFFFFFFFF, 4'b1111, "store_oor", rd, er);
    check("store_oor.err", {31'd0, er}, 32'd1);
    check("store_oor.rdata", rd, 32'd0);
    do_req(0, 1'b0, 32'hFFC, 32'h0, 4'b0000, "load_last", rd, er);
    check("load_last.rdata", rd, 32'hCAFEF00D);
    do_req(0, 1'b0, 32'h0, 32'h0, 4'b0000, "load_w0", rd, er);
    check("load_w0.rdata", rd, 32'h5A5A5A5A);

    // Backpressure: response held for 5 cycles while a second request waits.
    rsp_ready[0] = 1'b0;
    @(negedge clk);
    req_write[0] = 1'b0;
    req_addr[0]  = 32'h10;
    req_valid[0] = 1'b1;
    @(negedge clk);
    req_addr[0] = 32'hFFC;
    n = 1;
    while (rsp_valid[0] !== 1'b1 && n < 50) begin
      check("bp.req_ready_wait", {31'd0, req_ready[0]}, 32'd0);
      @(negedge clk);
      n++;
    end
    check("bp.latency", 32'(n), 32'd2);
    held = rsp_rdata[0];
    check("bp.rdata", held, 32'hDEADBEAA);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp.rsp_valid_held", {31'd0, rsp_valid[0]}, 32'd1);
      check("bp.rdata_held", rsp_rdata[0], 32'hDEADBEAA);
      check("bp.req_ready_held", {31'd0, req_ready[0]}, 32'd0);
    end
    $display("[TB] dut0 backpressure load addr=0x00000010 -> rdata=0x%08h held 5 cycles", held);
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    check("bp.rsp_released", {31'd0, rsp_valid[0]}, 32'd0);
    check("bp.req_ready_back", {31'd0, req_ready[0]}, 32'd1);
    @(negedge clk);
    req_valid[0] = 1'b0;
    n = 1;
    while (rsp_valid[0] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp2.latency", 32'(n), 32'd2);
    check("bp2.rdata", rsp_rdata[0], 32'hCAFEF00D);
    $display("[TB] dut0 queued load addr=0x00000ffc -> rdata=0x%08h", rsp_rdata[0]);
    @(negedge clk);

    // Four wait states: reset during WAIT abandons a store.
    do_req(1, 1'b1, 32'h20, 32'h11223344, 4'b1111, "ws4_store", rd, er);
    do_req(1, 1'b0, 32'h20, 32'h0, 4'b0000, "ws4_load", rd, er);
    check("ws4_load.rdata", rd, 32'h11223344);
    @(negedge clk);
    req_write[1] = 1'b1;
    req_addr[1]  = 32'h20;
    req_wdata[1] = 32'hFFFFFFFF;
    req_be[1]    = 4'b1111;
    req_valid[1] = 1'b1;
    @(negedge clk);
    req_valid[1] = 1'b0;
    @(negedge clk);
    check("abort.in_wait", {31'd0, req_ready[1]}, 32'd0);
    reset_n = 1'b0;
    #1;
    check("abort.req_ready", {31'd0, req_ready[1]}, 32'd1);
    check("abort.rsp_valid", {31'd0, rsp_valid[1]}, 32'd0);
    check("abort.rsp_rdata", rsp_rdata[1], 32'd0);
    check("abort.rsp_err", {31'd0, rsp_err[1]}, 32'd0);
    $display("[TB] dut1 store addr=0x00000020 abandoned by reset");
    @(negedge clk);
    reset_n = 1'b1;
    do_req(1, 1'b0, 32'h20, 32'h0, 4'b0000, "abort_load", rd, er);
    check("abort_load.rdata", rd, 32'h11223344);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
